hazard_unit: RTL and testbench

Pipeline interlock controller for the five-stage KLP32 core (IF, ID, IX, IM, IW). The bypass path resolves register hazards by forwarding. This block covers the cases forwarding cannot: load-use hazards, data-memory wait states and taken-branch redirects. It produces every hold, bubble and flush strobe for the pipeline registers, tracks memory-wait duration with a timeout watchdog, and keeps saturating performance counters.

---
 rtl/klp_pipe_pkg.sv | 21 ++
 rtl/hazard_unit_sat_counter.sv | 35 +++
 rtl/hazard_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/klp_pipe_pkg.sv
// Shared types for the KLP32 pipeline interlock logic.
// Holds the FSM state enum, register index width and a source-match helper.
package klp_pipe_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_t;

  function automatic logic src_hit(
    input logic                 en,
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] rd
  );
    return en && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports: clk, rst_n (sync, active low), inc, clr, count[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// KLP32 interlock: load-use, memory-wait and redirect hold/bubble/flush.
// In: ID/IX/IM hazard info, dmem_ready, perf_clr. Out: strobes, err, counters.
module hazard_unit
  import klp_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ix_valid,
  input  logic [REG_IDX_W-1:0] ix_rd,
  input  logic                 ix_is_load,
  input  logic                 ix_branch_taken,
  input  logic                 im_mem_req,
  input  logic                 dmem_ready,
  input  logic                 perf_clr,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 id_ix_hold,
  output logic                 ix_im_hold,
  output logic                 id_ix_bubble,
  output logic                 im_iw_bubble,
  output logic                 if_id_flush,
  output logic                 id_ix_flush,
  output logic                 mem_timeout_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(MEM_TIMEOUT);

  logic mem_stall;
  logic load_use;
  logic redirect;

  pipe_state_t       state;
  pipe_state_t       state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              err_q;
  logic              err_d;

  assign mem_stall = im_mem_req & ~dmem_ready;
  assign redirect  = ix_valid & ix_branch_taken;
  assign load_use  = id_valid & ix_valid & ix_is_load
                   & (ix_rd != REG_ZERO)
                   & (src_hit(id_uses_rs1, id_rs1, ix_rd)
                   |  src_hit(id_uses_rs2, id_rs2, ix_rd));

  // Conditions overlap, so first match wins.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ix_hold   = 1'b0;
    ix_im_hold   = 1'b0;
    id_ix_bubble = 1'b0;
    im_iw_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ix_flush  = 1'b0;
    if (rst_n) begin
      priority case (1'b1)
        mem_stall: begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ix_hold   = 1'b1;
          ix_im_hold   = 1'b1;
          im_iw_bubble = 1'b1;
        end
        redirect: begin
          if_id_flush = 1'b1;
          id_ix_flush = 1'b1;
        end
        load_use: begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ix_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    wait_d  = wait_q;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Flag rises on the edge where the count reaches the limit.
  always_comb begin
    err_d = err_q | (wait_d == WAIT_MAX);
    if (perf_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_hold),
    .clr   (perf_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .clr   (perf_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed cycles push expectations,
// a negedge monitor pops and compares strobes, flag, counters and state.
module tb_hazard_unit;
  import klp_pipe_pkg::*;

  localparam int CW = 4;
  localparam logic [7:0] NONE   = 8'b0000_0000;
  localparam logic [7:0] FREEZE = 8'b1111_0100;
  localparam logic [7:0] FLUSH  = 8'b0000_0011;
  localparam logic [7:0] LU     = 8'b1100_1000;

  typedef struct packed {
    logic [7:0]  ctl;
    logic        err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    pipe_state_t st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ix_rd;
  logic ix_valid, ix_is_load, ix_branch_taken;
  logic im_mem_req, dmem_ready, perf_clr;
  logic pc_hold, if_id_hold, id_ix_hold, ix_im_hold;
  logic id_ix_bubble, im_iw_bubble;
  logic if_id_flush, id_ix_flush, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ix_valid(ix_valid), .ix_rd(ix_rd), .ix_is_load(ix_is_load),
    .ix_branch_taken(ix_branch_taken),
    .im_mem_req(im_mem_req), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .id_ix_hold(id_ix_hold), .ix_im_hold(ix_im_hold),
    .id_ix_bubble(id_ix_bubble), .im_iw_bubble(im_iw_bubble),
    .if_id_flush(if_id_flush), .id_ix_flush(id_ix_flush),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic cmp(string nm, int act, int ex);
    n_chk++;
    if (act != ex) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, ex);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] ctl;
    if (q.size() > 0) begin
      e = q.pop_front();
      ctl = {pc_hold, if_id_hold, id_ix_hold, ix_im_hold,
             id_ix_bubble, im_iw_bubble,
             if_id_flush, id_ix_flush};
      cmp("ctl", int'(ctl), int'(e.ctl));
      cmp("err", int'(mem_timeout_err), int'(e.err));
      cmp("stall_cnt", int'(stall_cnt), int'(e.sc));
      cmp("flush_cnt", int'(flush_cnt), int'(e.fc));
      cmp("state", int'(dut.state), int'(e.st));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0; ix_rd = 0;
    ix_valid = 0; ix_is_load = 0; ix_branch_taken = 0;
    im_mem_req = 0; dmem_ready = 0; perf_clr = 0;
  endtask

  task automatic lu_vec();
    id_valid = 1; ix_valid = 1; ix_is_load = 1;
    ix_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
  endtask

  task automatic stall();
    im_mem_req = 1; dmem_ready = 0;
  endtask

  task automatic ex(logic [7:0] c, logic er, int sc, int fc,
                    pipe_state_t st);
    exp_t e;
    e.ctl = c; e.err = er;
    e.sc = CW'(sc); e.fc = CW'(fc); e.st = st;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 0;
    go(); lu_vec(); stall(); ex(NONE, 0, 0, 0, RUN);
    go(); ex(NONE, 0, 0, 0, RUN);
    rst_n = 1;
    go(); ex(NONE, 0, 0, 0, RUN);
    // load-use on rs2, then rs1
    go(); lu_vec(); ex(LU, 0, 0, 0, RUN);
    go(); ex(NONE, 0, 1, 0, RUN);
    go(); lu_vec(); id_rs2 = 0; id_uses_rs2 = 0;
    id_rs1 = 7; id_uses_rs1 = 1; ix_rd = 7;
    ex(LU, 0, 1, 0, RUN);
    // x0, unused operand, IX invalid
    go(); lu_vec(); ix_rd = 0; id_rs2 = 0;
    ex(NONE, 0, 2, 0, RUN);
    go(); lu_vec(); id_uses_rs2 = 0; ex(NONE, 0, 2, 0, RUN);
    go(); lu_vec(); ix_valid = 0; ex(NONE, 0, 2, 0, RUN);
    // priority
    go(); lu_vec(); ix_branch_taken = 1; ex(FLUSH, 0, 2, 0, RUN);
    go(); ex(NONE, 0, 2, 1, RUN);
    go(); lu_vec(); ix_branch_taken = 1; stall();
    ex(FREEZE, 0, 2, 1, RUN);
    go(); ex(NONE, 0, 3, 1, MEM_WAIT);
    go(); ex(NONE, 0, 3, 1, RUN);
    go(); perf_clr = 1; ex(NONE, 0, 3, 1, RUN);
    // three-cycle memory wait
    go(); stall(); ex(FREEZE, 0, 0, 0, RUN);
    go(); stall(); ex(FREEZE, 0, 1, 0, MEM_WAIT);
    go(); stall(); ex(FREEZE, 0, 2, 0, MEM_WAIT);
    go(); im_mem_req = 1; dmem_ready = 1; ex(NONE, 0, 3, 0, MEM_WAIT);
    go(); ex(NONE, 0, 3, 0, RUN);
    // ready on first request: no stall
    go(); im_mem_req = 1; dmem_ready = 1; ex(NONE, 0, 3, 0, RUN);
    go(); ex(NONE, 0, 3, 0, RUN);
    // watchdog, limit 4, six stall cycles
    for (int k = 1; k <= 6; k++) begin
      go(); stall();
      ex(FREEZE, (k >= 5), 2 + k, 0, (k == 1) ? RUN : MEM_WAIT);
    end
    go(); im_mem_req = 1; dmem_ready = 1; ex(NONE, 1, 9, 0, MEM_WAIT);
    go(); ex(NONE, 1, 9, 0, RUN);
    go(); perf_clr = 1; ex(NONE, 1, 9, 0, RUN);
    go(); ex(NONE, 0, 0, 0, RUN);
    // stall counter saturation, then clear beats increment
    for (int k = 1; k <= 17; k++) begin
      go(); lu_vec(); ex(LU, 0, (k - 1 > 15) ? 15 : k - 1, 0, RUN);
    end
    go(); ex(NONE, 0, 15, 0, RUN);
    go(); lu_vec(); perf_clr = 1; ex(LU, 0, 15, 0, RUN);
    go(); ex(NONE, 0, 0, 0, RUN);
    // reset mid-wait
    go(); stall(); ex(FREEZE, 0, 0, 0, RUN);
    go(); stall(); ex(FREEZE, 0, 1, 0, MEM_WAIT);
    go(); stall(); ix_valid = 1; ix_branch_taken = 1; rst_n = 0;
    ex(NONE, 0, 2, 0, MEM_WAIT);
    go(); rst_n = 1; ex(NONE, 0, 0, 0, RUN);
    go(); ix_valid = 1; ix_branch_taken = 1; ex(FLUSH, 0, 0, 0, RUN);
    go(); ex(NONE, 0, 0, 1, RUN);
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
